// File: rtl/sample_tick_receiver_pkg.sv
// sample_pkg: shared types and constants for the sample tick receiver.
// Ports: none (state enum, synchroniser depth, default sample width).
package sample_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sample_tick_receiver_if.sv
// sample_tick_receiver_if: request/valid link between receiver and source.
// Ports: master drives sample_req; slave drives sample_valid/sample_data.
interface sample_tick_receiver_if #(
  parameter int W = sample_pkg::SAMPLE_W
);

  logic         sample_req;
  logic         sample_valid;
  logic [W-1:0] sample_data;

  modport master (
    output sample_req,
    input  sample_valid,
    input  sample_data
  );

  modport slave (
    input  sample_req,
    output sample_valid,
    output sample_data
  );

endinterface

// File: rtl/sample_tick_receiver_sync.sv
// sync_edge_detect: async level -> registered one-cycle rising-edge tick.
// Ports: clk, rst (sync, high), async_in, tick.
module sync_edge_detect
  import sample_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  logic                   tick_q, tick_d;

  // vld gates ticks until the edge flop holds a real sample,
  // so a level already high at reset release is not an edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
    vld_d  = {vld_q[SYNC_STAGES-1:0], 1'b1};
    tick_d = sync_q[SYNC_STAGES-1] & ~edge_q
           & vld_q[SYNC_STAGES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      vld_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      vld_q  <= vld_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sample_tick_receiver.sv
// sample_tick_receiver: sample-clock tick, period/lock, sample handshake.
// Ports: clock_in, Reset, sample_clk, src (master), sample/period/lock outs.
module sample_tick_receiver #(
  parameter int                SAMPLE_W = sample_pkg::SAMPLE_W,
  parameter int                PERIOD_W = 28,
  parameter logic [PERIOD_W-1:0] TIMEOUT = 28'd4096
) (
  input  logic                clock_in,
  input  logic                Reset,
  input  logic                sample_clk,
  sample_tick_receiver_if.master src,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                period_strobe,
  output logic                locked,
  output logic                overrun,
  input  logic                ovr_clear
);

  import sample_pkg::*;

  logic tick;

  sync_edge_detect u_sync (
    .clk      (clock_in),
    .rst      (Reset),
    .async_in (sample_clk),
    .tick     (tick)
  );

  rx_state_t           state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                seen_q, seen_d;
  logic                pstb_q, pstb_d;
  logic                lock_q, lock_d;
  logic                ovr_q, ovr_d;
  logic                sstb_q, sstb_d;
  logic [SAMPLE_W-1:0] out_q, out_d;
  logic                report;
  logic                accept;
  logic                ovr_set;

  always_comb begin
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    period_d = period_q;
    pstb_d   = 1'b0;
    seen_d   = seen_q;
    lock_d   = lock_q;
    report   = tick & seen_q;
    if (tick) begin
      cnt_d  = PERIOD_W'(1);
      seen_d = 1'b1;
    end
    if (report) begin
      period_d = cnt_q;
      pstb_d   = 1'b1;
      lock_d   = (cnt_q == period_q);
    end else if (cnt_q == TIMEOUT) begin
      lock_d = 1'b0;
    end
  end

  // A tick landing with valid re-requests at once.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    accept  = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) state_d = REQ;
      end
      REQ: begin
        if (src.sample_valid) begin
          accept  = 1'b1;
          out_d   = src.sample_data;
          state_d = tick ? REQ : IDLE;
        end else if (tick) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    sstb_d = accept;
    ovr_d  = ovr_set | (ovr_q & ~ovr_clear);
  end

  always_ff @(posedge clock_in) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
      pstb_q   <= 1'b0;
      lock_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sstb_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      seen_q   <= seen_d;
      pstb_q   <= pstb_d;
      lock_q   <= lock_d;
      ovr_q    <= ovr_d;
      sstb_q   <= sstb_d;
      out_q    <= out_d;
    end
  end

  assign src.sample_req = (state_q == REQ);
  assign sample_out     = out_q;
  assign sample_strobe  = sstb_q;
  assign period         = period_q;
  assign period_strobe  = pstb_q;
  assign locked         = lock_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_sample_tick_receiver.sv
// tb_sample_tick_receiver: directed bench for sample_tick_receiver.
// Ports: none (drives divider model, source responder, checks outputs).
module tb_sample_tick_receiver;

  logic        clock_in   = 1'b0;
  logic        Reset      = 1'b1;
  logic        sample_clk = 1'b0;
  logic        ovr_clear  = 1'b0;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic [27:0] period;
  logic        period_strobe;
  logic        locked;
  logic        overrun;

  sample_tick_receiver_if sif ();

  sample_tick_receiver dut (
    .clock_in      (clock_in),
    .Reset         (Reset),
    .sample_clk    (sample_clk),
    .src           (sif),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .period        (period),
    .period_strobe (period_strobe),
    .locked        (locked),
    .overrun       (overrun),
    .ovr_clear     (ovr_clear)
  );

  always #5 clock_in = ~clock_in;

  int tests = 0;
  int fails = 0;

  int div     = 1024;
  int div_cnt = 0;
  bit div_en  = 0;
  bit man_en  = 0;
  bit man_val = 0;

  initial forever begin
    @(posedge clock_in);
    #2;
    if (div_en) begin
      sample_clk = (div_cnt >= div / 2);
      div_cnt = (div_cnt == div - 1) ? 0 : div_cnt + 1;
    end else if (man_en) begin
      sample_clk = man_val;
    end
  end

  int          ps_cnt      = 0;
  int          ss_cnt      = 0;
  int          req_rises   = 0;
  int          since       = 0;
  int          age         = 0;
  int          seq         = 0;
  logic [27:0] last_period = '0;
  logic [15:0] exp_data    = '0;
  bit          req_prev    = 0;
  bit          auto_resp   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
    if (period_strobe) begin
      ps_cnt++;
      last_period = period;
      since = 0;
    end else begin
      since++;
    end
    if (sample_strobe) ss_cnt++;
    if (sif.sample_req && !req_prev) req_rises++;
    req_prev = sif.sample_req;
    if (auto_resp) begin
      if (sample_strobe) chk("auto_data", sample_out, exp_data);
      if (sif.sample_valid) sif.sample_valid = 1'b0;
      if (sif.sample_req) begin
        age++;
        if (age == 2) begin
          seq++;
          exp_data = 16'hA000 + 16'(seq);
          sif.sample_data = exp_data;
          sif.sample_valid = 1'b1;
        end
      end else begin
        age = 0;
      end
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_req"}, sif.sample_req, 0);
    chk({tag, "_sstb"}, sample_strobe, 0);
    chk({tag, "_pstb"}, period_strobe, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_out"}, sample_out, 0);
    chk({tag, "_period"}, period, 0);
  endtask

  int ss0;
  int r0;

  initial begin
    sif.sample_valid = 1'b0;
    sif.sample_data  = '0;
    Reset = 1'b1;
    repeat (3) step();
    chk_reset("rst");
    Reset = 1'b0;
    repeat (5) step();

    auto_resp = 1;
    div = 1024;
    div_cnt = 0;
    div_en = 1;
    repeat (600) step();
    chk("first_tick_no_period", ps_cnt, 0);
    chk("first_tick_sample", ss_cnt, 1);
    repeat (1024) step();
    chk("second_period", last_period, 1024);
    chk("ps_after_2", ps_cnt, 1);
    chk("unlocked_after_2", locked, 0);
    repeat (1024) step();
    chk("locked_after_3", locked, 1);
    chk("strobe_per_tick", ss_cnt, 3);
    chk("req_per_tick", req_rises, 3);

    div_en = 0;
    for (int i = 0; i < 5000 && locked; i++) step();
    chk("timeout_unlocked", locked, 0);
    chk("timeout_cycle", since, 4096);

    div = 512;
    div_cnt = 0;
    div_en = 1;
    repeat (300) step();
    chk("resume_unlocked", locked, 0);
    repeat (512) step();
    chk("period_512", last_period, 512);
    chk("no_lock_yet", locked, 0);
    repeat (512) step();
    chk("relock", locked, 1);
    chk("period_512_again", last_period, 512);

    auto_resp = 0;
    sif.sample_valid = 1'b0;
    for (int i = 0; i < 600 && !sif.sample_req; i++) step();
    chk("ovr_req_seen", sif.sample_req, 1);
    ss0 = ss_cnt;
    repeat (520) step();
    chk("ovr_set", overrun, 1);
    chk("ovr_req_held", sif.sample_req, 1);
    chk("ovr_no_strobe", ss_cnt, ss0);
    sif.sample_data = 16'hBEEF;
    sif.sample_valid = 1'b1;
    step();
    sif.sample_valid = 1'b0;
    chk("beef_strobe", sample_strobe, 1);
    chk("beef_out", sample_out, 16'hBEEF);
    chk("beef_req_low", sif.sample_req, 0);
    repeat (5) step();
    chk("beef_one_strobe", ss_cnt, ss0 + 1);
    chk("ovr_sticky", overrun, 1);
    ovr_clear = 1'b1;
    step();
    ovr_clear = 1'b0;
    chk("ovr_cleared", overrun, 0);

    for (int i = 0; i < 600 && !sif.sample_req; i++) step();
    chk("same_req_seen", sif.sample_req, 1);
    repeat (511) step();
    sif.sample_data = 16'h5A5A;
    sif.sample_valid = 1'b1;
    step();
    sif.sample_valid = 1'b0;
    chk("same_tick_align", period_strobe, 1);
    chk("same_strobe", sample_strobe, 1);
    chk("same_out", sample_out, 16'h5A5A);
    chk("same_req_high", sif.sample_req, 1);
    chk("same_no_ovr", overrun, 0);

    div_en = 0;
    man_val = 1;
    man_en = 1;
    Reset = 1'b1;
    step();
    chk_reset("rst_mid");
    repeat (2) step();
    Reset = 1'b0;
    r0 = req_rises;
    repeat (10) step();
    chk("high_release_no_tick", req_rises, r0);
    chk("high_release_req", sif.sample_req, 0);
    man_val = 0;
    repeat (5) step();
    man_val = 1;
    repeat (3) step();
    chk("req_before_k3", sif.sample_req, 0);
    step();
    chk("req_at_k3", sif.sample_req, 1);
    chk("post_rst_no_pstb", period_strobe, 0);
    chk("post_rst_period", period, 0);

    sif.sample_data = 16'h7777;
    sif.sample_valid = 1'b1;
    step();
    sif.sample_valid = 1'b0;
    chk("min_rt_strobe", sample_strobe, 1);
    chk("min_rt_out", sample_out, 16'h7777);
    step();
    sif.sample_data = 16'h1234;
    sif.sample_valid = 1'b1;
    step();
    sif.sample_valid = 1'b0;
    chk("idle_no_strobe", sample_strobe, 0);
    chk("idle_out_kept", sample_out, 16'h7777);
    chk("idle_no_req", sif.sample_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
